shift_reg_univ: RTL and testbench

//   Universal shift register (74194-style) built from D-type storage cells: hold, shift right,

---
 rtl/shift_reg_pkg.sv | 26 ++
 rtl/usr_bit_cell.sv | 56 +++++
 rtl/shift_reg_univ.sv | 138 +++++++++++++
 tb/tb_shift_reg_univ.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
//   Shared definitions for the universal shift register (shift_reg_univ):
//   - shreg_mode_e : 2-bit operating mode encoding (hold / shr / shl / load)
//   - shreg_cnt_width() : width of the shifted-out counter for a given width
//   - SHREG_DEF_WIDTH / SHREG_DEF_CNT_W : defaults for the standard 4-bit build
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    // Operating mode as presented on the mode port.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shreg_mode_e;

    // Counter must represent 0..width inclusive, hence width+1 states.
    function automatic int shreg_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int SHREG_DEF_WIDTH = 4;
    localparam int SHREG_DEF_CNT_W = shreg_cnt_width(SHREG_DEF_WIDTH);

endpackage : shift_reg_pkg

// File: rtl/usr_bit_cell.sv
// -----------------------------------------------------------------------------
// usr_bit_cell
//   One storage bit of the universal shift register: a 4:1 next-state mux
//   (hold, upper neighbour, lower neighbour, parallel bit) feeding a
//   falling-edge D flop with asynchronous active-low clear.
// Ports:
//   clk      in   falling-edge clock
//   clr      in   asynchronous active-low clear (forces q to 0)
//   sel      in   [1:0] mode (shreg_mode_e encoding)
//   from_hi  in   value taken on shift right (bit i+1, or sr_in at the MSB)
//   from_lo  in   value taken on shift left  (bit i-1, or sl_in at the LSB)
//   load_bit in   value taken on parallel load
//   q        out  stored bit
//   q_next   out  value the flop will capture on the next falling edge
// -----------------------------------------------------------------------------
module usr_bit_cell
    import shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] sel,
    input  logic       from_hi,
    input  logic       from_lo,
    input  logic       load_bit,
    output logic       q,
    output logic       q_next
);

    logic q_q;
    logic q_d;

    // Next-state mux selecting the source for this bit.
    always_comb begin
        q_d = q_q;
        case (shreg_mode_e'(sel))
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = from_hi;
            MODE_SHL:  q_d = from_lo;
            MODE_LOAD: q_d = load_bit;
            default:   q_d = q_q;
        endcase
    end

    // Storage flop: falling edge, clear wins asynchronously.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign q_next = q_d;

endmodule : usr_bit_cell

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   74194-style universal shift register built from WIDTH usr_bit_cell
//   instances, plus a saturating count of bits shifted out since the last
//   parallel load and a registered "drained" flag.
//   Optional feature macro: SHREG_MATCH_EN adds a registered match output
//   (q == PATTERN, aligned with q). Without it, match and its comparator are
//   absent and PATTERN is unused.
// Ports:
//   clk        in   clock, all state changes on the falling edge
//   clr        in   asynchronous active-low reset
//   mode       in   [1:0] 00 hold, 01 shift right, 10 shift left, 11 load
//   sr_in      in   serial input entering q[WIDTH-1] on shift right
//   sl_in      in   serial input entering q[0] on shift left
//   d          in   [WIDTH-1:0] parallel load data
//   q          out  [WIDTH-1:0] register contents
//   ser_out_r  out  q[0], bit that leaves on shift right
//   ser_out_l  out  q[WIDTH-1], bit that leaves on shift left
//   shift_cnt  out  shifts since last load, saturating at WIDTH
//   drained    out  registered (shift_cnt == WIDTH)
//   match      out  registered (q == PATTERN), SHREG_MATCH_EN only
// -----------------------------------------------------------------------------
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int                 WIDTH   = SHREG_DEF_WIDTH,
    parameter logic [WIDTH-1:0]   PATTERN = WIDTH'(4'b1010)
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic [1:0]                          mode,
    input  logic                                sr_in,
    input  logic                                sl_in,
    input  logic [WIDTH-1:0]                    d,
    output logic [WIDTH-1:0]                    q,
    output logic                                ser_out_r,
    output logic                                ser_out_l,
    output logic [shreg_cnt_width(WIDTH)-1:0]   shift_cnt,
`ifdef SHREG_MATCH_EN
    output logic                                drained,
    output logic                                match
`else
    output logic                                drained
`endif
);

    localparam int               CNT_W   = shreg_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;

    logic [CNT_W-1:0] shift_cnt_q;
    logic [CNT_W-1:0] shift_cnt_d;
    logic             drained_q;
    logic             drained_d;

    // Neighbour wiring: bit i takes bit i+1 on shift right, bit i-1 on shift
    // left; the end cells take the serial inputs instead.
    assign hi_s = {sr_in, q_s[WIDTH-1:1]};
    assign lo_s = {q_s[WIDTH-2:0], sl_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell u_cell (
            .clk      (clk),
            .clr      (clr),
            .sel      (mode),
            .from_hi  (hi_s[i]),
            .from_lo  (lo_s[i]),
            .load_bit (d[i]),
            .q        (q_s[i]),
            .q_next   (q_next_s[i])
        );
    end

    // Shift counter next state: any shift counts (direction is not tracked),
    // saturating at WIDTH; a load restarts the count.
    always_comb begin
        shift_cnt_d = shift_cnt_q;
        case (shreg_mode_e'(mode))
            MODE_HOLD: shift_cnt_d = shift_cnt_q;
            MODE_SHR, MODE_SHL: begin
                if (shift_cnt_q == CNT_MAX) begin
                    shift_cnt_d = CNT_MAX;
                end else begin
                    shift_cnt_d = shift_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            MODE_LOAD: shift_cnt_d = {CNT_W{1'b0}};
            default:   shift_cnt_d = shift_cnt_q;
        endcase
        drained_d = (shift_cnt_d == CNT_MAX);
    end

    // Counter and drained flag; reset leaves the register fully drained.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            shift_cnt_q <= CNT_MAX;
            drained_q   <= 1'b1;
        end else begin
            shift_cnt_q <= shift_cnt_d;
            drained_q   <= drained_d;
        end
    end

    assign q         = q_s;
    assign ser_out_r = q_s[0];
    assign ser_out_l = q_s[WIDTH-1];
    assign shift_cnt = shift_cnt_q;
    assign drained   = drained_q;

`ifdef SHREG_MATCH_EN
    logic match_q;
    logic match_d;

    // Compare against the value q is about to take so match lines up with q.
    always_comb begin
        match_d = (q_next_s == PATTERN);
    end

    // Match register, cleared with the rest of the state.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`else
    logic unused_match_s;
    assign unused_match_s = ^{q_next_s, PATTERN};
`endif

endmodule : shift_reg_univ

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
//   Directed bench for shift_reg_univ (WIDTH=4, PATTERN=4'b1010). Inputs change
//   1 time unit after each falling edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

    logic       clk;
    logic       clr;
    logic [1:0] mode;
    logic       sr_in;
    logic       sl_in;
    logic [3:0] d;
    logic [3:0] q;
    logic       ser_out_r;
    logic       ser_out_l;
    logic [2:0] shift_cnt;
    logic       drained;
`ifdef SHREG_MATCH_EN
    logic       match;
`endif

    int checks   = 0;
    int failures = 0;

    shift_reg_univ #(.WIDTH(4), .PATTERN(4'b1010)) dut (
        .clk       (clk),
        .clr       (clr),
        .mode      (mode),
        .sr_in     (sr_in),
        .sl_in     (sl_in),
        .d         (d),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .shift_cnt (shift_cnt),
`ifdef SHREG_MATCH_EN
        .drained   (drained),
        .match     (match)
`else
        .drained   (drained)
`endif
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the active (falling) edge, then settle.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] eq, input logic [2:0] ecnt,
                             input logic edr);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".cnt"}, 32'(shift_cnt), 32'(ecnt));
        chk({tag, ".drained"}, 32'(drained), 32'(edr));
    endtask

    initial begin
        clr = 1'b0; mode = 2'b00; sr_in = 1'b0; sl_in = 1'b0; d = 4'b0000;
        #12;
        clr = 1'b1;

        // 1: reset asserted mid-cycle takes effect with no clock edge
        mode = 2'b11; d = 4'b0110;
        tick();
        chk_state("pre_rst", 4'b0110, 3'd0, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        chk_state("rst_async", 4'b0000, 3'd4, 1'b1);
`ifdef SHREG_MATCH_EN
        chk("rst_match", 32'(match), 32'd0);
`endif
        mode = 2'b11; d = 4'b1111;
        tick();
        chk_state("rst_ignore", 4'b0000, 3'd4, 1'b1);
        clr = 1'b1;

        // 2: load then hold
        mode = 2'b11; d = 4'b1011;
        tick();
        chk_state("load", 4'b1011, 3'd0, 1'b0);
        mode = 2'b00; d = 4'b0000;
        tick(); tick(); tick();
        chk_state("hold3", 4'b1011, 3'd0, 1'b0);

        // 3: shift right drain, ser_out_r sampled before each edge
        mode = 2'b01; sr_in = 1'b0;
        chk("shr.ser0", 32'(ser_out_r), 32'd1);
        tick();
        chk_state("shr1", 4'b0101, 3'd1, 1'b0);
        chk("shr.ser1", 32'(ser_out_r), 32'd1);
        tick();
        chk_state("shr2", 4'b0010, 3'd2, 1'b0);
        chk("shr.ser2", 32'(ser_out_r), 32'd0);
        tick();
        chk_state("shr3", 4'b0001, 3'd3, 1'b0);
        chk("shr.ser3", 32'(ser_out_r), 32'd1);
        tick();
        chk_state("shr4", 4'b0000, 3'd4, 1'b1);
        sr_in = 1'b1;
        tick();
        chk_state("shr_sat", 4'b1000, 3'd4, 1'b1);
        chk("shr.serl", 32'(ser_out_l), 32'd1);

        // 4: shift left filling with ones
        mode = 2'b11; d = 4'b0001;
        tick();
        chk_state("shl_load", 4'b0001, 3'd0, 1'b0);
        mode = 2'b10; sl_in = 1'b1;
        tick();
        chk_state("shl1", 4'b0011, 3'd1, 1'b0);
        tick();
        chk_state("shl2", 4'b0111, 3'd2, 1'b0);
        tick();
        chk_state("shl3", 4'b1111, 3'd3, 1'b0);

`ifdef SHREG_MATCH_EN
        // 5: match aligned with q
        mode = 2'b11; d = 4'b0101;
        tick();
        chk("m_load", 32'(match), 32'd0);
        mode = 2'b10; sl_in = 1'b0;
        tick();
        chk("m_q", 32'(q), 32'(4'b1010));
        chk("m_hit", 32'(match), 32'd1);
        mode = 2'b00;
        tick();
        chk("m_hold", 32'(match), 32'd1);
        mode = 2'b10;
        tick();
        chk("m_miss", 32'(match), 32'd0);
`endif

        // 6: async reset mid-shift, then recover
        mode = 2'b11; d = 4'b1011;
        tick();
        mode = 2'b01; sr_in = 1'b0;
        tick(); tick();
        chk_state("mid2", 4'b0010, 3'd2, 1'b0);
        #2;
        clr = 1'b0;
        #1;
        chk_state("mid_rst", 4'b0000, 3'd4, 1'b1);
        #1;
        clr = 1'b1;
        mode = 2'b11; d = 4'b1100;
        tick();
        chk_state("recover", 4'b1100, 3'd0, 1'b0);
        chk("recover.serl", 32'(ser_out_l), 32'd1);

        // Direction change mid-stream: both shifts count
        mode = 2'b01; sr_in = 1'b1;
        tick();
        chk_state("dir_shr", 4'b1110, 3'd1, 1'b0);
        mode = 2'b10; sl_in = 1'b0;
        tick();
        chk_state("dir_shl", 4'b1100, 3'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_reg_univ
